// File: rtl/dma_bus_arbiter.sv
// Purpose: shares the 7800 system bus between the 6502 and MARIA DMA, halting the CPU only on read boundaries.
// Latency: request->grant = cycles to next read phase_end + 1 + SETTLE_CYCLES; all outputs registered.
// Backpressure: dma_req is a level held until dma_done; bus returned on dma_done or after MAX_DMA cycles.
module dma_bus_arbiter #(
  parameter int               SETTLE_CYCLES  = 2,
  parameter int               RELEASE_CYCLES = 1,
  parameter int               CNT_W          = 12,
  parameter logic [CNT_W-1:0] MAX_DMA        = CNT_W'(454)
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             phase_end,
  input  logic             cpu_rw,
  input  logic             dma_req,
  input  logic             dma_done,
  output logic             halt_b,
  output logic             dma_gnt,
  output logic             rw_force_rd,
  output logic             db_sel_buf,
  output logic             wr_block,
  output logic [CNT_W-1:0] dma_cycles,
  output logic             timeout
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RD,
    SETTLE,
    DMA,
    RELEASE,
    UNHALT
  } state_t;

  // One phase counter serves both the SETTLE and RELEASE dwell times.
  localparam int PH_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST  = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  RELEASE_LAST = PH_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST      = MAX_DMA - CNT_ONE;
  localparam bit               TO_EN        = (MAX_DMA != '0);

  state_t            state, state_nxt;
  logic [PH_W-1:0]   ph_cnt, ph_nxt;
  logic [CNT_W-1:0]  cyc_nxt;
  logic              to_nxt;
  logic              at_limit;
  logic              halt_b_nxt, gnt_nxt, rw_nxt, db_nxt, wr_nxt;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt = state;
    ph_nxt    = ph_cnt + PH_W'(1);
    cyc_nxt   = dma_cycles;
    to_nxt    = 1'b0;
    at_limit  = TO_EN && (dma_cycles == TO_LAST);

    case (state)
      IDLE: begin
        // A read boundary in the same cycle as the request is taken immediately.
        if (dma_req) state_nxt = (phase_end && cpu_rw) ? SETTLE : WAIT_RD;
      end
      WAIT_RD: begin
        // Write cycles are never halted: the 6502 ignores RDY on writes.
        if (!dma_req)                 state_nxt = IDLE;
        else if (phase_end && cpu_rw) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (ph_cnt == SETTLE_LAST) begin
          state_nxt = DMA;
          cyc_nxt   = '0;
        end
      end
      DMA: begin
        if (dma_cycles != '1) cyc_nxt = dma_cycles + CNT_ONE;
        if (dma_done || at_limit) begin
          state_nxt = RELEASE;
          to_nxt    = at_limit;
        end
      end
      RELEASE: begin
        if (ph_cnt == RELEASE_LAST) state_nxt = UNHALT;
      end
      UNHALT: begin
        // The unhalting boundary gives the CPU at least one full cycle before re-halt.
        if (phase_end) state_nxt = dma_req ? WAIT_RD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) ph_nxt = '0;

    halt_b_nxt = (state_nxt == IDLE) || (state_nxt == WAIT_RD);
    gnt_nxt    = (state_nxt == DMA);
    rw_nxt     = (state_nxt == DMA);
    db_nxt     = (state_nxt == DMA) || (state_nxt == RELEASE);
    wr_nxt     = (state_nxt == SETTLE) || (state_nxt == DMA) || (state_nxt == RELEASE);
  end

  // State, counters and output flops; reset drops straight to IDLE with no release phase.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      ph_cnt      <= '0;
      dma_cycles  <= '0;
      timeout     <= 1'b0;
      halt_b      <= 1'b1;
      dma_gnt     <= 1'b0;
      rw_force_rd <= 1'b0;
      db_sel_buf  <= 1'b0;
      wr_block    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ph_cnt      <= ph_nxt;
      dma_cycles  <= cyc_nxt;
      timeout     <= to_nxt;
      halt_b      <= halt_b_nxt;
      dma_gnt     <= gnt_nxt;
      rw_force_rd <= rw_nxt;
      db_sel_buf  <= db_nxt;
      wr_block    <= wr_nxt;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Purpose: self-checking bench for dma_bus_arbiter against a cycle-level behavioural model.
// Latency: outputs compared every cycle on the falling edge; directed checks sampled 1ns after posedge.
// Backpressure: stimulus plays MARIA, holding dma_req until it issues dma_done.
module tb_dma_bus_arbiter;

  localparam int SETTLE  = 2;
  localparam int RELEASE = 1;
  localparam int MAXD    = 24;
  localparam int SAT     = 4095;

  localparam int P_IDLE = 0, P_WAIT = 1, P_SETTLE = 2, P_DMA = 3, P_REL = 4, P_UNHALT = 5;

  logic        sysclk = 1'b0;
  logic        reset, phase_end, cpu_rw, dma_req, dma_done;
  logic        halt_b, dma_gnt, rw_force_rd, db_sel_buf, wr_block, timeout;
  logic [11:0] dma_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  dma_bus_arbiter #(
    .SETTLE_CYCLES (SETTLE),
    .RELEASE_CYCLES(RELEASE),
    .CNT_W         (12),
    .MAX_DMA       (12'd24)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .phase_end  (phase_end),
    .cpu_rw     (cpu_rw),
    .dma_req    (dma_req),
    .dma_done   (dma_done),
    .halt_b     (halt_b),
    .dma_gnt    (dma_gnt),
    .rw_force_rd(rw_force_rd),
    .db_sel_buf (db_sel_buf),
    .wr_block   (wr_block),
    .dma_cycles (dma_cycles),
    .timeout    (timeout)
  );

  always #5 sysclk = ~sysclk;

  // Behavioural model: which phase the bus is in, plus remaining dwell and grant length.
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_dcyc  = 0;
  bit m_to    = 1'b0;
  bit armed   = 1'b0;

  always @(posedge sysclk) begin : model
    int  p, left, dcyc;
    bit  to, rd_edge, limit;
    p = m_phase; left = m_left; dcyc = m_dcyc; to = 1'b0;
    rd_edge = (phase_end === 1'b1) && (cpu_rw === 1'b1);
    if (reset === 1'b1) begin
      p = P_IDLE; left = 0; dcyc = 0;
    end else begin
      case (m_phase)
        P_IDLE:   if (dma_req) begin p = rd_edge ? P_SETTLE : P_WAIT; left = SETTLE; end
        P_WAIT:   if (!dma_req) p = P_IDLE;
                  else if (rd_edge) begin p = P_SETTLE; left = SETTLE; end
        P_SETTLE: begin left = left - 1; if (left == 0) begin p = P_DMA; dcyc = 0; end end
        P_DMA: begin
          limit = (MAXD != 0) && (m_dcyc == MAXD - 1);
          if (dcyc < SAT) dcyc = dcyc + 1;
          if (dma_done || limit) begin p = P_REL; left = RELEASE; to = limit; end
        end
        P_REL:    begin left = left - 1; if (left == 0) p = P_UNHALT; end
        P_UNHALT: if (phase_end) p = dma_req ? P_WAIT : P_IDLE;
        default:  p = P_IDLE;
      endcase
    end
    m_phase <= p;
    m_left  <= left;
    m_dcyc  <= dcyc;
    m_to    <= to;
    if (reset === 1'b1) armed <= 1'b1;
  end

  logic prev_gnt  = 1'b0;
  logic prev_halt = 1'b1;

  // Every-cycle comparison of all outputs against the model, plus the grant invariants.
  always @(negedge sysclk) begin
    logic [17:0] exp_v, act_v;
    if (armed) begin
      exp_v = {m_phase == P_IDLE || m_phase == P_WAIT,
               m_phase == P_DMA,
               m_phase == P_DMA,
               m_phase == P_DMA || m_phase == P_REL,
               m_phase == P_SETTLE || m_phase == P_DMA || m_phase == P_REL,
               m_to,
               12'(m_dcyc)};
      act_v = {halt_b, dma_gnt, rw_force_rd, db_sel_buf, wr_block, timeout, dma_cycles};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t {halt,gnt,rw,db,wr,to,cyc} act=%h exp=%h", $time, act_v, exp_v);
      end
      if (dma_gnt === 1'b1) begin
        n_checks++;
        if ({halt_b, wr_block, rw_force_rd, db_sel_buf} !== 4'b0111) begin
          n_fail++;
          $display("FAIL gnt_invariant t=%0t {halt,wr,rw,db} act=%b exp=0111", $time,
                   {halt_b, wr_block, rw_force_rd, db_sel_buf});
        end
        if (prev_gnt !== 1'b1) begin
          n_checks++;
          if (prev_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_rise_halted t=%0t prev_halt act=%b exp=0", $time, prev_halt);
          end
        end
      end
    end
    prev_gnt  = dma_gnt;
    prev_halt = halt_b;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  int gap;

  initial begin
    reset = 1'b1; phase_end = 1'b0; cpu_rw = 1'b1; dma_req = 1'b0; dma_done = 1'b0;
    tick(); tick();
    chk("reset_halt_b", int'(halt_b), 1);
    chk("reset_outputs", int'({dma_gnt, rw_force_rd, db_sel_buf, wr_block, timeout}), 0);
    chk("reset_cycles", int'(dma_cycles), 0);
    reset = 1'b0;

    // Request with read boundary at cycle 3.
    dma_req = 1'b1;
    tick(); tick(); tick();
    chk("req_no_boundary_halt_b", int'(halt_b), 1);
    phase_end = 1'b1; cpu_rw = 1'b1;
    tick();
    phase_end = 1'b0;
    chk("read_boundary_halt_b", int'(halt_b), 0);
    chk("settle_wr_block", int'(wr_block), 1);
    chk("settle_no_gnt", int'(dma_gnt), 0);
    tick();
    chk("settle2_no_gnt", int'(dma_gnt), 0);
    tick();
    chk("grant_at_cycle6", int'(dma_gnt), 1);
    chk("grant_cycles_cleared", int'(dma_cycles), 0);

    // Normal burst of 20 grant cycles.
    repeat (19) tick();
    chk("burst_cycles_19", int'(dma_cycles), 19);
    dma_done = 1'b1; dma_req = 1'b0;
    tick();
    dma_done = 1'b0;
    chk("burst_gnt_drop", int'(dma_gnt), 0);
    chk("burst_cycles_20", int'(dma_cycles), 20);
    chk("burst_release_db", int'({db_sel_buf, wr_block, halt_b, rw_force_rd, timeout}), 5'b11000);
    tick();
    chk("burst_db_drop", int'({db_sel_buf, wr_block, halt_b}), 0);
    tick(); tick();
    chk("unhalt_waits", int'(halt_b), 0);
    phase_end = 1'b1; cpu_rw = 1'b0;
    tick();
    phase_end = 1'b0;
    chk("unhalt_on_phase_end", int'(halt_b), 1);

    // Request during a CPU write; read boundary three cycles later.
    dma_req = 1'b1; phase_end = 1'b1; cpu_rw = 1'b0;
    tick();
    phase_end = 1'b0;
    chk("write_not_halted", int'(halt_b), 1);
    tick(); tick();
    chk("write_still_running", int'(halt_b), 1);
    phase_end = 1'b1; cpu_rw = 1'b1;
    tick();
    phase_end = 1'b0;
    chk("halt_after_write", int'(halt_b), 0);

    // Timeout with no dma_done.
    tick(); tick();
    chk("to_grant", int'(dma_gnt), 1);
    repeat (MAXD - 1) tick();
    chk("to_before_limit", int'({dma_gnt, timeout}), 2'b10);
    chk("to_before_cycles", int'(dma_cycles), MAXD - 1);
    tick();
    chk("to_forced_release", int'({dma_gnt, timeout}), 2'b01);
    chk("to_cycles", int'(dma_cycles), MAXD);

    // Back-to-back: request still high through UNHALT.
    tick();
    chk("to_single_pulse", int'(timeout), 0);
    chk("b2b_unhalt_state", int'({halt_b, db_sel_buf}), 0);
    phase_end = 1'b1; cpu_rw = 1'b1;
    tick();
    phase_end = 1'b0;
    chk("b2b_cpu_runs", int'({halt_b, wr_block}), 2'b10);
    tick(); tick();
    chk("b2b_still_running", int'({halt_b, dma_gnt}), 2'b10);
    phase_end = 1'b1; cpu_rw = 1'b1;
    tick();
    phase_end = 1'b0;
    chk("b2b_rehalt", int'(halt_b), 0);
    tick(); tick();
    chk("b2b_regrant", int'(dma_gnt), 1);
    repeat (4) tick();

    // Reset during grant, then a stray dma_done in IDLE.
    reset = 1'b1; dma_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("midgrant_reset", int'({halt_b, dma_gnt, rw_force_rd, db_sel_buf, wr_block, timeout}), 6'b100000);
    chk("midgrant_reset_cycles", int'(dma_cycles), 0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("idle_done_ignored", int'({halt_b, dma_gnt, rw_force_rd, db_sel_buf, wr_block, timeout}), 6'b100000);
    chk("idle_done_cycles", int'(dma_cycles), 0);

    // Randomized traffic checked by the model on every cycle.
    gap = 2;
    for (int i = 0; i < 4000; i++) begin
      if (gap == 0) begin
        phase_end = 1'b1;
        cpu_rw    = ($urandom % 3) != 0;
        gap       = $urandom_range(2, 5);
      end else begin
        phase_end = 1'b0;
        gap       = gap - 1;
      end
      dma_done = 1'b0;
      reset    = (($urandom % 600) == 0);
      if (dma_req) begin
        if (dma_gnt && (($urandom % 14) == 0)) begin
          dma_done = 1'b1;
          dma_req  = (($urandom % 3) == 0);
        end else if (!dma_gnt && (($urandom % 60) == 0)) begin
          dma_req = 1'b0;
        end
      end else begin
        dma_req = (($urandom % 6) == 0);
      end
      if (($urandom % 70) == 0) dma_done = 1'b1;
      tick();
    end
    reset = 1'b0; dma_req = 1'b0; dma_done = 1'b0; phase_end = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
